// File: rtl/ifetch.sv
// ifetch - instruction fetch stage feeding decode.
//
// Keeps the fetch PC, issues one read at a time on a req/gnt + rvalid
// instruction-memory port and hands each fetched word to decode with a
// registered one-cycle loadInstr pulse. Decode back-pressure (stall) parks a
// returned word in a one-entry hold buffer. A redirect replaces the fetch PC
// and squashes any wrong-path word still in flight. A misaligned redirect
// target is fatal: fetch_err latches and fetching stops until reset.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   stall                      decode cannot accept an instruction this cycle
//   redirect, redirect_pc      taken branch/jump and its target
//   imem_req, imem_addr        read request / address (address = fetch PC)
//   imem_gnt                   request accepted this cycle
//   imem_rvalid, imem_rdata    read response (one per granted request)
//   loadInstr                  one-cycle pulse: instruction/pc valid
//   instruction, pc            delivered word and its address
//   fetch_err                  sticky misaligned-redirect flag
module ifetch #(
  parameter int unsigned          I_WIDTH  = 32,
  parameter int unsigned          A_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               imem_req,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [I_WIDTH-1:0] imem_rdata,
  output logic               loadInstr,
  output logic [I_WIDTH-1:0] instruction,
  output logic [A_WIDTH-1:0] pc,
  output logic               fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic               kill_q, kill_d;
  logic [I_WIDTH-1:0] hold_q, hold_d;
  logic               load_q, load_d;
  logic [I_WIDTH-1:0] instr_q, instr_d;
  logic [A_WIDTH-1:0] pc_q, pc_d;
  logic               err_q, err_d;

  logic [A_WIDTH-1:0] pc_plus4;

  // Wraps naturally modulo 2^A_WIDTH.
  assign pc_plus4 = fetch_pc_q + A_WIDTH'(4);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    hold_d     = hold_q;
    load_d     = 1'b0;
    instr_d    = instr_q;
    pc_d       = pc_q;
    err_d      = err_q;

    if (redirect && (state_q != S_HALT)) begin
      if (redirect_pc[1:0] != 2'b00) begin
        err_d   = 1'b1;
        kill_d  = 1'b0;
        state_d = S_HALT;
      end else begin
        fetch_pc_d = redirect_pc;
        kill_d     = 1'b0;
        state_d    = S_REQ;
        // A request is (or becomes) outstanding without its data yet: its
        // response must be swallowed before the new target is requested.
        if ((state_q == S_REQ && imem_gnt) || (state_q == S_WAIT && !imem_rvalid)) begin
          kill_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_gnt) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (!stall) begin
              load_d     = 1'b1;
              instr_d    = imem_rdata;
              pc_d       = fetch_pc_q;
              fetch_pc_d = pc_plus4;
              state_d    = S_REQ;
            end else begin
              // fetch_pc_q still holds this word's address while parked.
              hold_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load_d     = 1'b1;
            instr_d    = hold_q;
            pc_d       = fetch_pc_q;
            fetch_pc_d = pc_plus4;
            state_d    = S_REQ;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      hold_q     <= '0;
      load_q     <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      hold_q     <= hold_d;
      load_q     <= load_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = fetch_pc_q;
  assign loadInstr   = load_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch - bench for ifetch: directed cycle table, hand-written reset /
// wrap sequence on a second instance with RESET_PC = 0xFFFF_FFFC, and a
// randomized run checked against a transaction-level fetch model.
module tb_ifetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, load_instr, fetch_err;
  logic [31:0] imem_addr, instruction, pc;

  ifetch #(.I_WIDTH(32), .A_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .loadInstr(load_instr), .instruction(instruction), .pc(pc),
    .fetch_err(fetch_err)
  );

  // Second instance (RESET_PC near the top of the address space)
  logic        w_rst_n = 1'b0;
  logic        w_stall = 1'b0, w_redirect = 1'b0, w_gnt = 1'b0, w_rvalid = 1'b0;
  logic [31:0] w_redirect_pc = '0, w_rdata = '0;
  logic        w_req, w_load, w_err;
  logic [31:0] w_addr, w_instr, w_pc;

  ifetch #(.I_WIDTH(32), .A_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_w (
    .clk(clk), .rst_n(w_rst_n), .stall(w_stall), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .loadInstr(w_load), .instruction(w_instr), .pc(w_pc),
    .fetch_err(w_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall, gnt, rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_load;
    logic [31:0] e_instr, e_pc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic gn, input logic rv,
                              input logic [31:0] rd, input logic rdr, input logic [31:0] rp,
                              input logic er, input logic [31:0] ea, input logic el,
                              input logic [31:0] ei, input logic [31:0] ep, input logic ee);
    vec_t v;
    v.stall = st; v.gnt = gn; v.rvalid = rv; v.rdata = rd; v.redirect = rdr; v.rpc = rp;
    v.e_req = er; v.e_addr = ea; v.e_load = el; v.e_instr = ei; v.e_pc = ep; v.e_err = ee;
    vecs.push_back(v);
  endfunction

  // Memory image used by the random run: every address holds a distinct word.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic main_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 0; redirect = 0; redirect_pc = '0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random-run model state
  logic [31:0] exp_next, oaddr;
  logic        halted, outst, last_stall, last_red;
  int          cnt, deliv;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- directed table ----------------
    // Test 1: first fetch at 0x0, 1-cycle latency
    add(0,1,0,32'h0,0,32'h0,        0,32'h0,  0,32'h0,       32'h0,  0);
    add(0,1,0,32'h0,0,32'h0,        1,32'h0,  0,32'h0,       32'h0,  0);
    add(0,0,1,32'h0050_0093,0,32'h0,0,32'h0,  0,32'h0,       32'h0,  0);
    // Test 2: grant withheld for 5 cycles, address stable at 0x4
    add(0,0,0,32'h0,0,32'h0,        1,32'h4,  1,32'h0050_0093,32'h0, 0);
    for (int i = 0; i < 4; i++)
      add(0,0,0,32'h0,0,32'h0,      1,32'h4,  0,32'h0050_0093,32'h0, 0);
    add(0,1,0,32'h0,0,32'h0,        1,32'h4,  0,32'h0050_0093,32'h0, 0);
    // Test 3: stall for 3 cycles when the word returns
    add(1,0,1,32'h1111_1111,0,32'h0,0,32'h0,  0,32'h0050_0093,32'h0, 0);
    add(1,0,0,32'h0,0,32'h0,        0,32'h0,  0,32'h0050_0093,32'h0, 0);
    add(1,0,0,32'h0,0,32'h0,        0,32'h0,  0,32'h0050_0093,32'h0, 0);
    add(0,0,0,32'h0,0,32'h0,        0,32'h0,  0,32'h0050_0093,32'h0, 0);
    add(0,1,0,32'h0,0,32'h0,        1,32'h8,  1,32'h1111_1111,32'h4, 0);
    // Test 4a: redirect in WAIT, stale word arrives 2 cycles later
    add(0,0,0,32'h0,1,32'h100,      0,32'h0,  0,32'h1111_1111,32'h4, 0);
    add(0,0,0,32'h0,0,32'h0,        0,32'h0,  0,32'h1111_1111,32'h4, 0);
    add(0,0,1,32'hDEAD_BEEF,0,32'h0,0,32'h0,  0,32'h1111_1111,32'h4, 0);
    add(0,1,0,32'h0,0,32'h0,        1,32'h100,0,32'h1111_1111,32'h4, 0);
    add(0,0,1,32'h2222_2222,0,32'h0,0,32'h0,  0,32'h1111_1111,32'h4, 0);
    add(0,1,0,32'h0,0,32'h0,        1,32'h104,1,32'h2222_2222,32'h100,0);
    // Test 4b: redirect in the same cycle as rvalid
    add(0,0,1,32'hBAD0_BAD0,1,32'h200,0,32'h0,0,32'h2222_2222,32'h100,0);
    add(0,1,0,32'h0,0,32'h0,        1,32'h200,0,32'h2222_2222,32'h100,0);
    add(0,0,1,32'h3333_3333,0,32'h0,0,32'h0,  0,32'h2222_2222,32'h100,0);
    // Redirect in REQ without grant, then in REQ with grant (kill path)
    add(0,0,0,32'h0,1,32'h300,      1,32'h204,1,32'h3333_3333,32'h200,0);
    add(0,1,0,32'h0,1,32'h400,      1,32'h300,0,32'h3333_3333,32'h200,0);
    add(0,0,1,32'h0BAD_BAD0,0,32'h0,0,32'h0,  0,32'h3333_3333,32'h200,0);
    add(0,1,0,32'h0,0,32'h0,        1,32'h400,0,32'h3333_3333,32'h200,0);
    add(0,0,1,32'h4444_4444,0,32'h0,0,32'h0,  0,32'h3333_3333,32'h200,0);
    add(0,1,0,32'h0,0,32'h0,        1,32'h404,1,32'h4444_4444,32'h400,0);
    // Redirect while holding a stalled word: buffer discarded
    add(1,0,1,32'h5555_5555,0,32'h0,0,32'h0,  0,32'h4444_4444,32'h400,0);
    add(1,0,0,32'h0,1,32'h500,      0,32'h0,  0,32'h4444_4444,32'h400,0);
    add(0,1,0,32'h0,0,32'h0,        1,32'h500,0,32'h4444_4444,32'h400,0);
    add(0,0,1,32'h6666_6666,0,32'h0,0,32'h0,  0,32'h4444_4444,32'h400,0);
    // Test 5: misaligned redirect -> HALT with sticky error
    add(0,0,0,32'h0,1,32'h102,      1,32'h504,1,32'h6666_6666,32'h500,0);
    for (int i = 0; i < 4; i++)
      add(0,1,1,32'h7777_7777,0,32'h0,0,32'h0,0,32'h6666_6666,32'h500,1);

    main_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rvalid;
      imem_rdata = vecs[i].rdata; redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_load", i), {31'b0, load_instr}, {31'b0, vecs[i].e_load});
      chk($sformatf("vec%0d_instr", i), instruction, vecs[i].e_instr);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_err", i), {31'b0, fetch_err}, {31'b0, vecs[i].e_err});
      @(negedge clk);
    end

    // HALT only left through reset
    rst_n = 1'b0;
    stall = 0; redirect = 0; imem_gnt = 0; imem_rvalid = 0;
    #1;
    chk("halt_reset_err", {31'b0, fetch_err}, 32'h0);
    chk("halt_reset_instr", instruction, 32'h0);
    chk("halt_reset_pc", pc, 32'h0);

    // ---------------- Test 6: wrap and async reset mid-WAIT ----------------
    @(negedge clk);
    w_rst_n = 1'b1;
    chk("w_idle_req", {31'b0, w_req}, 32'h0);
    @(negedge clk);
    chk("w_first_req", {31'b0, w_req}, 32'h1);
    chk("w_first_addr", w_addr, 32'hFFFF_FFFC);
    w_gnt = 1'b1;
    @(negedge clk);
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h0A0A_0A0A;
    @(negedge clk);
    w_rvalid = 1'b0;
    chk("w_load", {31'b0, w_load}, 32'h1);
    chk("w_instr", w_instr, 32'h0A0A_0A0A);
    chk("w_pc", w_pc, 32'hFFFF_FFFC);
    chk("w_wrap_addr", w_addr, 32'h0);
    chk("w_wrap_req", {31'b0, w_req}, 32'h1);
    w_gnt = 1'b1;
    @(negedge clk);
    w_gnt = 1'b0;
    #2 w_rst_n = 1'b0;
    #1;
    chk("w_rst_req", {31'b0, w_req}, 32'h0);
    chk("w_rst_load", {31'b0, w_load}, 32'h0);
    chk("w_rst_instr", w_instr, 32'h0);
    chk("w_rst_pc", w_pc, 32'h0);
    chk("w_rst_err", {31'b0, w_err}, 32'h0);
    @(negedge clk);
    w_rvalid = 1'b1; w_rdata = 32'hBADB_AD00;
    @(negedge clk);
    w_rst_n = 1'b1;
    chk("w_post_idle_req", {31'b0, w_req}, 32'h0);
    @(negedge clk);
    w_rvalid = 1'b0;
    chk("w_post_req", {31'b0, w_req}, 32'h1);
    chk("w_post_addr", w_addr, 32'hFFFF_FFFC);
    chk("w_post_load", {31'b0, w_load}, 32'h0);
    @(negedge clk);
    chk("w_late_ignored_load", {31'b0, w_load}, 32'h0);
    chk("w_late_ignored_instr", w_instr, 32'h0);
    chk("w_still_req", {31'b0, w_req}, 32'h1);

    // ---------------- randomized run vs. fetch model ----------------
    for (int ep = 0; ep < 3; ep++) begin
      main_reset();
      exp_next = 32'h0; halted = 0; outst = 0; last_stall = 0; last_red = 0;
      cnt = 0; deliv = 0; oaddr = '0;
      for (int c = 0; c < 400; c++) begin
        if (halted) begin
          chk("rnd_halt_req", {31'b0, imem_req}, 32'h0);
          chk("rnd_halt_load", {31'b0, load_instr}, 32'h0);
          chk("rnd_halt_err", {31'b0, fetch_err}, 32'h1);
        end else begin
          chk("rnd_err", {31'b0, fetch_err}, 32'h0);
          if (load_instr) begin
            chk("rnd_load_gate", {30'b0, last_stall, last_red}, 32'h0);
            chk("rnd_pc", pc, exp_next);
            chk("rnd_instr", instruction, mem(exp_next));
            exp_next = exp_next + 32'h4;
            deliv++;
          end
          if (imem_req) chk("rnd_addr", imem_addr, exp_next);
        end

        stall = ($urandom_range(0, 9) < 3);
        redirect = 1'b0;
        redirect_pc = $urandom;
        if (c == 350) begin
          redirect = 1'b1;
          redirect_pc = ($urandom & 32'hFFFF_FFFC) | 32'h2;
        end else if (c < 350 && $urandom_range(0, 11) == 0) begin
          redirect = 1'b1;
          if ($urandom_range(0, 3) == 0)
            redirect_pc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
          else
            redirect_pc = $urandom_range(0, 4095) & 32'hFFFF_FFFC;
        end
        imem_gnt = 1'($urandom_range(0, 1));
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
        if (outst) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem(oaddr);
            outst = 0;
          end
        end
        if (imem_req && imem_gnt) begin
          outst = 1;
          oaddr = imem_addr;
          cnt = $urandom_range(1, 3);
        end
        if (!halted && redirect) begin
          if (redirect_pc[1:0] != 2'b00) halted = 1;
          else exp_next = redirect_pc;
        end
        last_stall = stall;
        last_red = redirect;
        @(negedge clk);
      end
      chk("rnd_progress", {31'b0, (deliv >= 10)}, 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
